// File: rtl/clkdiv_pkg.sv
// Shared widths, reset divisor and per-channel state layout for the clkdiv_multi divider.
package clkdiv_pkg;

   localparam int unsigned CLKDIV_WIDTH_DEF   = 32;
   localparam int unsigned CLKDIV_DEFAULT_DIV = 50_000_000;

   // Fields sized for the widest supported divisor; narrower channels use the low bits.
   typedef struct packed {
      logic [CLKDIV_WIDTH_DEF-1:0] div;
      logic [CLKDIV_WIDTH_DEF-1:0] count;
      logic [CLKDIV_WIDTH_DEF-1:0] shadow;
      logic                        pending;
   } clkdiv_state_t;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, one-deep divisor shadow, wrap-aligned apply, tick/square registers.
module clkdiv_channel
   import clkdiv_pkg::*;
#(
   parameter int unsigned      WIDTH       = CLKDIV_WIDTH_DEF,
   parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(CLKDIV_DEFAULT_DIV)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync,
   input  logic             load,
   input  logic [WIDTH-1:0] load_div,
   output logic             pending,
   output logic             tick,
   output logic             clk_o
);

   localparam int unsigned SW  = CLKDIV_WIDTH_DEF;
   localparam int unsigned WP1 = WIDTH + 1;

   clkdiv_state_t    state_q;
   clkdiv_state_t    state_d;
   logic             tick_q;
   logic             tick_d;
   logic             out_q;
   logic             out_d;
   logic [WIDTH-1:0] div_w;
   logic [WIDTH-1:0] count_w;
   logic [WIDTH-1:0] last_w;
   logic [WIDTH:0]   half_w;
   logic             stopped;
   logic             at_last;
   logic             apply;

   // Next state: a divisor change only lands on a period boundary, disable, sync or while stopped.
   always_comb begin
      div_w   = state_q.div[WIDTH-1:0];
      count_w = state_q.count[WIDTH-1:0];
      last_w  = div_w - WIDTH'(1);
      half_w  = ({1'b0, div_w} + WP1'(1)) >> 1;
      stopped = (div_w == '0);
      at_last = ~stopped & (count_w == last_w);
      apply   = ~en | sync | stopped | at_last;
      tick_d  = en & at_last;
      out_d   = en & ~stopped & ({1'b0, count_w} < half_w);
      state_d = state_q;
      if (apply) begin
         state_d.count   = '0;
         state_d.pending = 1'b0;
         if (load) begin
            state_d.div = SW'(load_div);
         end else if (state_q.pending) begin
            state_d.div = state_q.shadow;
         end
      end else begin
         state_d.count = SW'(count_w + WIDTH'(1));
         if (load) begin
            state_d.shadow  = SW'(load_div);
            state_d.pending = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= '{div: SW'(DEFAULT_DIV), count: '0, shadow: '0, pending: 1'b0};
         tick_q  <= 1'b0;
         out_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         out_q   <= out_d;
      end
   end

   assign pending = state_q.pending;
   assign tick    = tick_q;
   assign clk_o   = out_q;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider: config decode, ready mux and sync fan-out.
// Optional CLKDIV_SYNC_EN adds sync_i, a phase-restart strobe for all channels.
module clkdiv_multi
   import clkdiv_pkg::*;
#(
   parameter int unsigned      WIDTH       = CLKDIV_WIDTH_DEF,
   parameter int unsigned      CHANNELS    = 4,
   parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(CLKDIV_DEFAULT_DIV),
   localparam int unsigned     CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
`ifdef CLKDIV_SYNC_EN
   input  logic                sync_i,
`endif
   input  logic [CHANNELS-1:0] en_i,
   input  logic                cfg_valid_i,
   output logic                cfg_ready_o,
   input  logic [CW-1:0]       cfg_chan_i,
   input  logic [WIDTH-1:0]    cfg_div_i,
   output logic [CHANNELS-1:0] tick_o,
   output logic [CHANNELS-1:0] clk_o
);

   logic [CHANNELS-1:0] sel;
   logic [CHANNELS-1:0] pending;
   logic [CHANNELS-1:0] load;
   logic                sync_w;

   // Out-of-range channel numbers match no select line, so they are never ready.
   always_comb begin
      sel = '0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
         sel[c] = (cfg_chan_i == CW'(c));
      end
   end

   assign cfg_ready_o = |(sel & ~pending);
   assign load        = {CHANNELS{cfg_valid_i}} & sel & ~pending;

`ifdef CLKDIV_SYNC_EN
   assign sync_w = sync_i;
`else
   assign sync_w = 1'b0;
`endif

   for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_chan
      clkdiv_channel #(
         .WIDTH       (WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (en_i[g]),
         .sync     (sync_w),
         .load     (load[g]),
         .load_div (cfg_div_i),
         .pending  (pending[g]),
         .tick     (tick_o[g]),
         .clk_o    (clk_o[g])
      );
   end

endmodule
